// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: walks T0..T6 and drives one-hot datapath
// strobes for the reg-reg ALU, mul/div, nop and halt instructions.
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             mem_rdy,
  input  logic             stop,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             HIin,
  output logic             LOin,
  output logic [3:0]       rsel,
  output logic             Rin,
  output logic             Rout,
  output logic [4:0]       alu_op,
  output logic             run,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_t;

  typedef struct packed {
    logic       pcout, marin, incpc, zin, zlowout, zhighout, read, mdrin;
    logic       mdrout, irin, yin, hiin, loin, rin, rout;
    logic [3:0] rsel;
    logic [4:0] alu_op;
  } ctl_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_HALT = 5'b11001;

  state_t           r_state;
  ctl_t             r_ctl;
  logic             r_run;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_op;
  logic [3:0]       r_ra, r_rb, r_rc;
  logic             r_stop_seen;

  state_t     w_ns;
  logic [4:0] w_op;
  logic [3:0] w_ra, w_rb, w_rc;
  logic       w_is_alu, w_is_md, w_retire;
  state_t     w_done;
  logic       w_unused;

  assign w_unused = ^ir[14:0];

  // Strobes for the state being entered; T3 decode sees the IR directly
  // because the fields are latched on that same edge.
  function automatic ctl_t decode_ctl(state_t s, logic [4:0] op, logic [3:0] ra,
                                      logic [3:0] rb, logic [3:0] rc);
    ctl_t c;
    logic md;
    c  = '0;
    md = (op == OP_MUL) || (op == OP_DIV);
    case (s)
      S_T0: begin c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1; c.zin = 1'b1; end
      S_T1: begin c.zlowout = 1'b1; c.read = 1'b1; c.mdrin = 1'b1; end
      S_T2: begin c.mdrout = 1'b1; c.irin = 1'b1; end
      S_T3: begin c.rsel = md ? ra : rb; c.rout = 1'b1; c.yin = 1'b1; end
      S_T4: begin c.rsel = md ? rb : rc; c.rout = 1'b1; c.zin = 1'b1; c.alu_op = op; end
      S_T5: begin
        c.zlowout = 1'b1;
        if (md) c.loin = 1'b1;
        else begin c.rsel = ra; c.rin = 1'b1; end
      end
      S_T6: begin c.zhighout = 1'b1; c.hiin = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_op     = (r_state == S_T2) ? ir[31:27] : r_op;
    w_ra     = (r_state == S_T2) ? ir[26:23] : r_ra;
    w_rb     = (r_state == S_T2) ? ir[22:19] : r_rb;
    w_rc     = (r_state == S_T2) ? ir[18:15] : r_rc;
    w_is_alu = (w_op >= OP_ADD) && (w_op <= OP_ROL);
    w_is_md  = (w_op == OP_MUL) || (w_op == OP_DIV);
    w_done   = (r_stop_seen || stop) ? S_HALT : S_T0;
    w_retire = 1'b0;
    w_ns     = r_state;
    case (r_state)
      S_T0: w_ns = S_T1;
      S_T1: if (mem_rdy) w_ns = S_T2;
      S_T2: begin
        if (w_is_alu || w_is_md) w_ns = S_T3;
        else begin
          w_retire = 1'b1;
          w_ns     = (w_op == OP_HALT) ? S_HALT : w_done;
        end
      end
      S_T3: w_ns = S_T4;
      S_T4: w_ns = S_T5;
      S_T5: begin
        if (w_is_md) w_ns = S_T6;
        else begin w_retire = 1'b1; w_ns = w_done; end
      end
      S_T6: begin w_retire = 1'b1; w_ns = w_done; end
      default: w_ns = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= S_T0;
      r_ctl       <= '0;
      r_run       <= 1'b1;
      r_cnt       <= '0;
      r_op        <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_rc        <= '0;
      r_stop_seen <= 1'b0;
    end else begin
      r_state <= w_ns;
      r_ctl   <= decode_ctl(w_ns, w_op, w_ra, w_rb, w_rc);
      r_run   <= (w_ns != S_HALT);
      if (w_retire) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (r_state == S_T2) begin
        r_op <= ir[31:27];
        r_ra <= ir[26:23];
        r_rb <= ir[22:19];
        r_rc <= ir[18:15];
      end
      if (w_ns == S_T0)  r_stop_seen <= 1'b0;
      else if (stop)     r_stop_seen <= 1'b1;
    end
  end

  // PCin is the one strobe qualified by mem_rdy in the same cycle: it marks
  // the T1 cycle whose memory data is actually valid.
  assign PCin        = (r_state == S_T1) && mem_rdy;
  assign PCout       = r_ctl.pcout;
  assign MARin       = r_ctl.marin;
  assign IncPC       = r_ctl.incpc;
  assign Zin         = r_ctl.zin;
  assign Zlowout     = r_ctl.zlowout;
  assign Zhighout    = r_ctl.zhighout;
  assign Read        = r_ctl.read;
  assign MDRin       = r_ctl.mdrin;
  assign MDRout      = r_ctl.mdrout;
  assign IRin        = r_ctl.irin;
  assign Yin         = r_ctl.yin;
  assign HIin        = r_ctl.hiin;
  assign LOin        = r_ctl.loin;
  assign Rin         = r_ctl.rin;
  assign Rout        = r_ctl.rout;
  assign rsel        = r_ctl.rsel;
  assign alu_op      = r_ctl.alu_op;
  assign run         = r_run;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle strobe vectors against
// hand-computed expectations, plus a continuous single-bus-driver monitor.
module tb_control_sequencer;

  localparam int CNT_W = 16;

  logic             gclk = 1'b0;
  logic             clr, mem_rdy, stop;
  logic [31:0]      ir;
  logic             PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin;
  logic             MDRout, IRin, Yin, HIin, LOin, Rin, Rout, run;
  logic [3:0]       rsel;
  logic [4:0]       alu_op;
  logic [CNT_W-1:0] instr_count;

  int n_chk  = 0;
  int n_pass = 0;
  logic mon_en = 1'b0;

  // strobe vector: PCout MARin IncPC Zin Zlowout Zhighout PCin Read MDRin MDRout IRin Yin HIin LOin Rin Rout
  logic [15:0] strb;
  assign strb = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin,
                 MDRout, IRin, Yin, HIin, LOin, Rin, Rout};

  localparam logic [15:0] S_NONE = 16'h0000;
  localparam logic [15:0] S_T0   = 16'hF000;
  localparam logic [15:0] S_T1R  = 16'h0B80;
  localparam logic [15:0] S_T1W  = 16'h0980;
  localparam logic [15:0] S_T2   = 16'h0060;
  localparam logic [15:0] S_A3   = 16'h0011;
  localparam logic [15:0] S_X4   = 16'h1001;
  localparam logic [15:0] S_A5   = 16'h0802;
  localparam logic [15:0] S_M5   = 16'h0804;
  localparam logic [15:0] S_M6   = 16'h0408;

  localparam logic [31:0] IR_AND = 32'h2891_8000;
  localparam logic [31:0] IR_MUL = {5'b01110, 4'd4, 4'd5, 4'd0, 15'd0};
  localparam logic [31:0] IR_UND = {5'b11111, 4'd1, 4'd2, 4'd3, 15'd0};
  localparam logic [31:0] IR_ADD = {5'b00011, 4'd6, 4'd7, 4'd8, 15'd0};

  control_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(gclk), .clr(clr), .ir(ir), .mem_rdy(mem_rdy), .stop(stop),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .rsel(rsel), .Rin(Rin),
    .Rout(Rout), .alu_op(alu_op), .run(run), .instr_count(instr_count)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic exp_cyc(input string tag, input logic [15:0] s, input logic [3:0] rs,
                         input logic [4:0] op);
    chk({tag, ".strb"}, {16'd0, strb}, {16'd0, s});
    chk({tag, ".rsel"}, {28'd0, rsel}, {28'd0, rs});
    chk({tag, ".alu_op"}, {27'd0, alu_op}, {27'd0, op});
  endtask

  task automatic tick;
    @(posedge gclk);
    #2;
  endtask

  always @(negedge gclk)
    if (mon_en)
      chk("busdrv", {31'd0, $countones({PCout, Zlowout, Zhighout, MDRout, Rout}) <= 1}, 32'd1);

  initial begin
    clr = 1'b0; mem_rdy = 1'b1; stop = 1'b0; ir = IR_AND;
    #12;
    exp_cyc("rst", S_NONE, 4'd0, 5'd0);
    chk("rst.run", {31'd0, run}, 32'd1);
    chk("rst.cnt", {16'd0, instr_count}, 32'd0);
    clr = 1'b1;
    mon_en = 1'b1;

    // and R1,R2,R3 with no wait states: T0..T5 = 6 cycles
    tick; exp_cyc("and.T1", S_T1R, 4'd0, 5'd0);
    tick; exp_cyc("and.T2", S_T2, 4'd0, 5'd0);
    tick; exp_cyc("and.T3", S_A3, 4'd2, 5'd0);
    tick; exp_cyc("and.T4", S_X4, 4'd3, 5'b00101);
    tick; exp_cyc("and.T5", S_A5, 4'd1, 5'd0);
    chk("and.cnt_pre", {16'd0, instr_count}, 32'd0);
    tick; exp_cyc("and.T0", S_T0, 4'd0, 5'd0);
    chk("and.cnt", {16'd0, instr_count}, 32'd1);

    // same instruction, three wait states in T1: 9 cycles
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick; exp_cyc($sformatf("wait.T1w%0d", i), S_T1W, 4'd0, 5'd0);
    end
    tick; mem_rdy = 1'b1; #1;
    exp_cyc("wait.T1r", S_T1R, 4'd0, 5'd0);
    tick; exp_cyc("wait.T2", S_T2, 4'd0, 5'd0);
    tick; exp_cyc("wait.T3", S_A3, 4'd2, 5'd0);
    tick; exp_cyc("wait.T4", S_X4, 4'd3, 5'b00101);
    tick; exp_cyc("wait.T5", S_A5, 4'd1, 5'd0);
    tick; exp_cyc("wait.T0", S_T0, 4'd0, 5'd0);
    chk("wait.cnt", {16'd0, instr_count}, 32'd2);

    // mul R4,R5: 7 cycles, single retire at end of T6
    ir = IR_MUL;
    tick; exp_cyc("mul.T1", S_T1R, 4'd0, 5'd0);
    tick; exp_cyc("mul.T2", S_T2, 4'd0, 5'd0);
    tick; exp_cyc("mul.T3", S_A3, 4'd4, 5'd0);
    tick; exp_cyc("mul.T4", S_X4, 4'd5, 5'b01110);
    tick; exp_cyc("mul.T5", S_M5, 4'd0, 5'd0);
    tick; exp_cyc("mul.T6", S_M6, 4'd0, 5'd0);
    chk("mul.cnt_pre", {16'd0, instr_count}, 32'd2);
    tick; exp_cyc("mul.T0", S_T0, 4'd0, 5'd0);
    chk("mul.cnt", {16'd0, instr_count}, 32'd3);

    // undefined opcode runs as nop: 3 cycles, no execute strobes
    ir = IR_UND;
    tick; exp_cyc("und.T1", S_T1R, 4'd0, 5'd0);
    tick; exp_cyc("und.T2", S_T2, 4'd0, 5'd0);
    tick; exp_cyc("und.T0", S_T0, 4'd0, 5'd0);
    chk("und.cnt", {16'd0, instr_count}, 32'd4);

    // asynchronous reset in the middle of T4
    ir = IR_ADD;
    tick; tick; tick;
    tick; exp_cyc("rst4.T4", S_X4, 4'd8, 5'b00011);
    #2 clr = 1'b0;
    #1;
    exp_cyc("rst4.async", S_NONE, 4'd0, 5'd0);
    chk("rst4.cnt", {16'd0, instr_count}, 32'd0);
    chk("rst4.run", {31'd0, run}, 32'd1);
    #2 clr = 1'b1;
    tick; exp_cyc("rst4.T1", S_T1R, 4'd0, 5'd0);
    tick; exp_cyc("rst4.T2", S_T2, 4'd0, 5'd0);
    tick; exp_cyc("rst4.T3", S_A3, 4'd7, 5'd0);
    tick; exp_cyc("rst4.T4b", S_X4, 4'd8, 5'b00011);
    tick; exp_cyc("rst4.T5", S_A5, 4'd6, 5'd0);
    tick; exp_cyc("rst4.T0", S_T0, 4'd0, 5'd0);
    chk("rst4.cnt1", {16'd0, instr_count}, 32'd1);

    // stop pulsed in T3: finish through T5 then halt for good
    tick; tick;
    tick; stop = 1'b1; exp_cyc("stop.T3", S_A3, 4'd7, 5'd0);
    tick; stop = 1'b0; exp_cyc("stop.T4", S_X4, 4'd8, 5'b00011);
    tick; exp_cyc("stop.T5", S_A5, 4'd6, 5'd0);
    chk("stop.run5", {31'd0, run}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick;
      mem_rdy = i[0];
      stop    = i[1];
      #1;
      exp_cyc($sformatf("halt%0d", i), S_NONE, 4'd0, 5'd0);
      chk($sformatf("halt%0d.run", i), {31'd0, run}, 32'd0);
      chk($sformatf("halt%0d.cnt", i), {16'd0, instr_count}, 32'd2);
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
